mcpu_prog_loader: RTL and testbench

Upstream stage of MCPU. Receives a byte stream with a valid/ready handshake and writes the program image into the MCPU instruction/data RAM as 16-bit words. Holds the CPU in reset until the image is loaded and its checksum has passed. Replaces bench-side direct memory pokes and gives the CPU a synthesizable boot path.

---
 rtl/mcpu_prog_loader.sv | 132 +++++++++++++
 tb/tb_mcpu_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_prog_loader.sv
// Boot loader for MCPU: takes a COUNT/data/CHK byte stream, writes 16-bit words
// into program RAM and releases the CPU reset once the checksum matches.
module mcpu_prog_loader #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter bit CLEAR_MEM  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_HDR, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic [ADDR_WIDTH:0]   index, index_next;
  logic [ADDR_WIDTH:0]   index_inc;
  logic [7:0]            chk, chk_next;
  logic [7:0]            hi, hi_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [WORD_WIDTH-1:0] wdata_next;
  logic                  xfer;

  assign xfer      = in_valid && in_ready;
  assign index_inc = index + 1'b1;

  always_comb begin
    state_next = state;
    count_next = count;
    index_next = index;
    chk_next   = chk;
    hi_next    = hi;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (CLEAR_MEM) begin
            state_next = S_CLEAR;
            addr_next  = '0;
            wdata_next = '0;
          end else begin
            state_next = S_HDR;
          end
        end
      end
      // mem_addr is the address being zeroed this cycle; advance until the top
      S_CLEAR: begin
        if (mem_addr == '1) state_next = S_HDR;
        else                addr_next  = mem_addr + 1'b1;
      end
      S_HDR: begin
        if (xfer) begin
          // COUNT of zero stands for a full 2**ADDR_WIDTH-word image
          if (in_data == 8'h00) count_next = {1'b1, {ADDR_WIDTH{1'b0}}};
          else                  count_next = (ADDR_WIDTH+1)'(in_data);
          chk_next   = in_data;
          index_next = '0;
          state_next = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_next    = in_data;
          chk_next   = chk ^ in_data;
          state_next = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          chk_next   = chk ^ in_data;
          addr_next  = index[ADDR_WIDTH-1:0];
          wdata_next = {hi, in_data};
          state_next = S_WR;
        end
      end
      S_WR: begin
        index_next = index_inc;
        state_next = (index_inc == count) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (xfer) state_next = (in_data == chk) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      index     <= '0;
      chk       <= '0;
      hi        <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      index     <= index_next;
      chk       <= chk_next;
      hi        <= hi_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      mem_we    <= (state_next == S_CLEAR) || (state_next == S_WR);
      in_ready  <= (state_next == S_HDR) || (state_next == S_HI) ||
                   (state_next == S_LO)  || (state_next == S_CHK);
      cpu_reset <= (state_next != S_DONE);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Directed bench for mcpu_prog_loader: one instance with the clear phase, one without.
`timescale 1ns/1ps
module tb_mcpu_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  logic        rdy1, we1, crst1, done1, err1;
  logic [7:0]  addr1;
  logic [15:0] wd1;
  logic        rdy0, we0, crst0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] wd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] img  [0:255];
  logic [15:0] prog [0:9];

  // write logs, one per instance
  logic [7:0]  la1 [0:2047];
  logic [15:0] ld1 [0:2047];
  int          n1 = 0;
  logic [7:0]  la0 [0:2047];
  logic [15:0] ld0 [0:2047];
  int          n0 = 0;

  always #5 clock = ~clock;

  mcpu_prog_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(8), .CLEAR_MEM(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_reset(crst1), .done(done1), .error(err1));

  mcpu_prog_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(8), .CLEAR_MEM(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_reset(crst0), .done(done0), .error(err0));

  always @(posedge clock) begin
    #1;
    if (we1 && n1 < 2048) begin la1[n1] = addr1; ld1[n1] = wd1; n1++; end
    if (we0 && n0 < 2048) begin la0[n0] = addr0; ld0[n0] = wd0; n0++; end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Offer one byte and hold it until the selected instance takes it.
  task automatic send_byte(input bit which, input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (((which ? rdy0 : rdy1) !== 1'b1) && n < 600) begin tick(); n++; end
    if (n >= 600) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout byte=%02h never accepted (required in_ready=1)", b);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input bit which, input int n, input logic [7:0] flip, input bit gaps);
    logic [7:0]  x;
    logic [15:0] w;
    x = n[7:0];
    send_byte(which, n[7:0], gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      send_byte(which, w[15:8], gaps);
      send_byte(which, w[7:0], gaps);
      x = x ^ w[15:8] ^ w[7:0];
    end
    send_byte(which, x ^ flip, gaps);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (rdy1 !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", rdy1); end
    n_checks++; if (we1 !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_we got=%b want=0", we1); end
    n_checks++; if (addr1 !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr got=%h want=00", addr1); end
    n_checks++; if (wd1 !== 16'h0)   begin n_fail++; $display("FAIL reset_mem_wdata got=%h want=0000", wd1); end
    n_checks++; if (crst1 !== 1'b1)  begin n_fail++; $display("FAIL reset_cpu_reset got=%b want=1", crst1); end
    n_checks++; if (done1 !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b want=0", done1); end
    n_checks++; if (err1 !== 1'b0)   begin n_fail++; $display("FAIL reset_error got=%b want=0", err1); end
    n_checks++; if (crst0 !== 1'b1 || rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_dut0 got cpu_reset=%b in_ready=%b want 1/0", crst0, rdy0); end
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (rdy1 !== 1'b0 || crst1 !== 1'b1) begin n_fail++; $display("FAIL idle_outputs got in_ready=%b cpu_reset=%b want 0/1", rdy1, crst1); end
  endtask

  task automatic test_hailstone();
    int base;
    for (int i = 0; i < 10; i++) img[i] = prog[i];
    base = n1;
    pulse_start(1'b0);
    n_checks++; if (we1 !== 1'b1 || addr1 !== 8'h00 || wd1 !== 16'h0) begin n_fail++; $display("FAIL clear_first got we=%b addr=%h data=%h want 1/00/0000", we1, addr1, wd1); end
    send_stream(1'b0, 10, 8'h00, 1'b0);
    n_checks++; if (crst1 !== 1'b0) begin n_fail++; $display("FAIL hail_cpu_reset got=%b want=0", crst1); end
    n_checks++; if (done1 !== 1'b1 || err1 !== 1'b0) begin n_fail++; $display("FAIL hail_done got done=%b error=%b want 1/0", done1, err1); end
    tick(); tick();
    n_checks++; if (n1 - base !== 266) begin n_fail++; $display("FAIL hail_write_count got=%0d want=266", n1 - base); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (la1[base+i] !== i[7:0] || ld1[base+i] !== 16'h0) begin
        n_fail++; $display("FAIL hail_clear[%0d] got addr=%h data=%h want %h/0000", i, la1[base+i], ld1[base+i], i[7:0]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (la1[base+256+i] !== i[7:0] || ld1[base+256+i] !== prog[i]) begin
        n_fail++; $display("FAIL hail_word[%0d] got addr=%h data=%h want %h/%h", i, la1[base+256+i], ld1[base+256+i], i[7:0], prog[i]);
      end
    end
  endtask

  task automatic test_checksum_error();
    for (int i = 0; i < 10; i++) img[i] = prog[i];
    pulse_start(1'b0);
    n_checks++; if (done1 !== 1'b0 || crst1 !== 1'b1) begin n_fail++; $display("FAIL restart_clears got done=%b cpu_reset=%b want 0/1", done1, crst1); end
    send_stream(1'b0, 10, 8'h01, 1'b0);
    repeat (3) tick();
    n_checks++; if (err1 !== 1'b1)  begin n_fail++; $display("FAIL chkerr_error got=%b want=1", err1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL chkerr_done got=%b want=0", done1); end
    n_checks++; if (crst1 !== 1'b1) begin n_fail++; $display("FAIL chkerr_cpu_reset got=%b want=1", crst1); end
    pulse_start(1'b0);
    send_stream(1'b0, 10, 8'h00, 1'b0);
    n_checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || crst1 !== 1'b0) begin n_fail++; $display("FAIL chkerr_recover got done=%b error=%b cpu_reset=%b want 1/0/0", done1, err1, crst1); end
  endtask

  task automatic test_backpressure();
    int base;
    for (int i = 0; i < 10; i++) img[i] = prog[i];
    base = n1;
    pulse_start(1'b0);
    send_stream(1'b0, 10, 8'h00, 1'b1);
    tick(); tick();
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL gaps_done got=%b want=1", done1); end
    n_checks++; if (n1 - base !== 266) begin n_fail++; $display("FAIL gaps_write_count got=%0d want=266", n1 - base); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (la1[base+256+i] !== i[7:0] || ld1[base+256+i] !== prog[i]) begin
        n_fail++; $display("FAIL gaps_word[%0d] got addr=%h data=%h want %h/%h", i, la1[base+256+i], ld1[base+256+i], i[7:0], prog[i]);
      end
    end
  endtask

  task automatic test_n_zero();
    int base;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin b = i[7:0]; img[i] = {b, ~b}; end
    base = n0;
    pulse_start(1'b1);
    n_checks++; if (we0 !== 1'b0 || rdy0 !== 1'b1) begin n_fail++; $display("FAIL n0_no_clear got we=%b in_ready=%b want 0/1", we0, rdy0); end
    send_stream(1'b1, 256, 8'h00, 1'b0);
    n_checks++; if (done0 !== 1'b1 || crst0 !== 1'b0) begin n_fail++; $display("FAIL n0_done got done=%b cpu_reset=%b want 1/0", done0, crst0); end
    tick(); tick();
    n_checks++; if (n0 - base !== 256) begin n_fail++; $display("FAIL n0_write_count got=%0d want=256", n0 - base); end
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      n_checks++;
      if (la0[base+i] !== b || ld0[base+i] !== {b, ~b}) begin
        n_fail++; $display("FAIL n0_word[%0d] got addr=%h data=%h want %h/%h", i, la0[base+i], ld0[base+i], b, {b, ~b});
      end
    end
    n_checks++; if (la0[base+255] !== 8'hFF || ld0[base+255] !== 16'hFF00) begin n_fail++; $display("FAIL n0_last got addr=%h data=%h want ff/ff00", la0[base+255], ld0[base+255]); end
  endtask

  task automatic test_reset_midload();
    int base;
    for (int i = 0; i < 10; i++) img[i] = prog[i];
    pulse_start(1'b0);
    send_byte(1'b0, 8'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b0, prog[i][15:8], 1'b0);
      send_byte(1'b0, prog[i][7:0], 1'b0);
    end
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (we1 !== 1'b0 || addr1 !== 8'h00 || wd1 !== 16'h0) begin n_fail++; $display("FAIL midrst_mem got we=%b addr=%h data=%h want 0/00/0000", we1, addr1, wd1); end
    n_checks++; if (crst1 !== 1'b1 || rdy1 !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got cpu_reset=%b in_ready=%b want 1/0", crst1, rdy1); end
    n_checks++; if (done1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got done=%b error=%b want 0/0", done1, err1); end
    tick();
    reset = 1'b1;
    tick();
    base = n1;
    pulse_start(1'b0);
    send_stream(1'b0, 10, 8'h00, 1'b0);
    tick(); tick();
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_done got=%b want=1", done1); end
    n_checks++; if (n1 - base !== 266) begin n_fail++; $display("FAIL midrst_write_count got=%0d want=266", n1 - base); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (la1[base+256+i] !== i[7:0] || ld1[base+256+i] !== prog[i]) begin
        n_fail++; $display("FAIL midrst_word[%0d] got addr=%h data=%h want %h/%h", i, la1[base+256+i], ld1[base+256+i], i[7:0], prog[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int base;
    base = n1;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    pulse_start(1'b0);
    n_checks++; if (rdy1 !== 1'b1 || we1 !== 1'b0) begin n_fail++; $display("FAIL ign_state got in_ready=%b we=%b want 1/0", rdy1, we1); end
    send_byte(1'b0, 8'hAB, 1'b0);
    send_byte(1'b0, 8'hCD, 1'b0);
    n_checks++; if (we1 !== 1'b1 || addr1 !== 8'h00 || wd1 !== 16'hABCD) begin n_fail++; $display("FAIL ign_write got we=%b addr=%h data=%h want 1/00/abcd", we1, addr1, wd1); end
    tick();
    n_checks++; if (we1 !== 1'b0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL ign_wr_one_cycle got we=%b in_ready=%b want 0/1", we1, rdy1); end
    send_byte(1'b0, 8'h67, 1'b0);
    n_checks++; if (done1 !== 1'b1 || crst1 !== 1'b0) begin n_fail++; $display("FAIL ign_done got done=%b cpu_reset=%b want 1/0", done1, crst1); end
    tick();
    n_checks++; if (n1 - base !== 257) begin n_fail++; $display("FAIL ign_write_count got=%0d want=257", n1 - base); end
    n_checks++; if (la1[base+256] !== 8'h00 || ld1[base+256] !== 16'hABCD) begin n_fail++; $display("FAIL ign_logged got addr=%h data=%h want 00/abcd", la1[base+256], ld1[base+256]); end
  endtask

  initial begin
    prog[0] = 16'h1188; prog[1] = 16'h2101; prog[2] = 16'h3402; prog[3] = 16'h4503;
    prog[4] = 16'h5A10; prog[5] = 16'h6C21; prog[6] = 16'h7F04; prog[7] = 16'h8800;
    prog[8] = 16'h9E05; prog[9] = 16'hF000;
    test_reset();
    test_hailstone();
    test_checksum_error();
    test_backpressure();
    test_n_zero();
    test_reset_midload();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
